// File: rtl/router_b_seq.sv
// rtl/router_b_seq.sv - route-word micro-sequencer for router_b
// Issues programmed route words one per handshake until a last-marked word or the end of memory.
module router_b_seq #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [8:0]    prog_data,
  input  logic          op_ready,
  output logic [1:0]    sel_R,
  output logic [1:0]    sel_S,
  output logic          inv_R,
  output logic          inv_S,
  output logic [1:0]    sel_I,
  output logic          op_valid,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] pc
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [AW-1:0] PC_ZERO = '0;
  localparam logic [AW-1:0] PC_MAX  = AW'(DEPTH - 1);

  logic [1:0]    state;
  logic          last_q;
  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] pc_next;
  logic          handshake;

  assign pc_next   = pc + 1'b1;
  assign handshake = op_valid & op_ready;

  // Program memory has no reset so a program survives rst/abort.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && prog_we) begin
      mem[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state    <= S_IDLE;
      {last_q, sel_I, inv_S, inv_R, sel_S, sel_R} <= '0;
      op_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pc       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            // Reads pre-write contents of word 0 if it is written this same cycle.
            state    <= S_ISSUE;
            pc       <= '0;
            {last_q, sel_I, inv_S, inv_R, sel_S, sel_R} <= mem[PC_ZERO];
            op_valid <= 1'b1;
            busy     <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (handshake) begin
            if (last_q || pc == PC_MAX) begin
              state    <= S_DONE;
              {last_q, sel_I, inv_S, inv_R, sel_S, sel_R} <= '0;
              op_valid <= 1'b0;
              done     <= 1'b1;
            end else begin
              pc <= pc_next;
              {last_q, sel_I, inv_S, inv_R, sel_S, sel_R} <= mem[pc_next];
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_router_b_seq.sv
// tb/tb_router_b_seq.sv - scoreboard testbench for router_b_seq
module tb_router_b_seq;

  logic       clk = 1'b0;
  logic       rst, start, abort, prog_we, op_ready;
  logic [3:0] prog_addr;
  logic [8:0] prog_data;
  logic [1:0] sel_R, sel_S, sel_I;
  logic       inv_R, inv_S, op_valid, busy, done;
  logic [3:0] pc;
  logic [7:0] route;

  typedef struct {
    bit         is_done;
    logic [3:0] pc;
    logic [7:0] route;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [8:0] prog16 [16];

  assign route = {sel_I, inv_S, inv_R, sel_S, sel_R};

  always #5 clk = ~clk;

  router_b_seq #(.DEPTH(16), .AW(4)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .op_ready(op_ready), .sel_R(sel_R), .sel_S(sel_S), .inv_R(inv_R),
    .inv_S(inv_S), .sel_I(sel_I), .op_valid(op_valid), .busy(busy),
    .done(done), .pc(pc)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic push_op(input logic [3:0] p, input logic [7:0] r);
    exp_t e;
    e.is_done = 1'b0; e.pc = p; e.route = r;
    exp_q.push_back(e);
  endtask

  task automatic push_done(input logic [3:0] p);
    exp_t e;
    e.is_done = 1'b1; e.pc = p; e.route = 8'h00;
    exp_q.push_back(e);
  endtask

  // Monitor: every accepted operation and every done pulse consumes one expectation.
  always @(negedge clk) begin
    if (!rst && ((op_valid && op_ready) || done)) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_output: valid=%0b done=%0b pc=%0d route=%0h, expected nothing", op_valid, done, pc, route);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.is_done != done || e.pc !== pc || (!done && e.route !== route)) begin
          n_bad++;
          $display("FAIL scoreboard: got done=%0b pc=%0d route=%0h expected done=%0b pc=%0d route=%0h",
                   done, pc, route, e.is_done, e.pc, e.route);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [3:0] a, input logic [8:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || op_valid || done) && n < 200) begin
      tick();
      n++;
    end
    check({name, "_timeout"}, 16'(n >= 200), 16'd0);
  endtask

  task automatic check_quiet(input string name);
    check({name, "_valid"}, 16'(op_valid), 16'd0);
    check({name, "_busy"},  16'(busy),     16'd0);
    check({name, "_done"},  16'(done),     16'd0);
    check({name, "_pc"},    16'(pc),       16'd0);
    check({name, "_route"}, 16'(route),    16'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; prog_we = 1'b0;
    prog_addr = '0; prog_data = '0; op_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check_quiet("reset");

    // Three-word program, word 2 marked last.
    write_word(4'd0, 9'h01B);
    write_word(4'd1, 9'h0A5);
    write_word(4'd2, 9'h1C6);
    push_op(4'd0, 8'h1B); push_op(4'd1, 8'hA5); push_op(4'd2, 8'hC6); push_done(4'd2);
    op_ready = 1'b1;
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t1_back_to_back_valid", 16'(op_valid), 16'd1);
    end
    @(negedge clk);
    check("t1_done_pulse", 16'(done), 16'd1);
    tick();
    wait_idle("t1");
    check("t1_busy_after", 16'(busy), 16'd0);

    // Stall: route word 0 must hold while op_ready is low.
    op_ready = 1'b0;
    push_op(4'd0, 8'h1B); push_op(4'd1, 8'hA5); push_op(4'd2, 8'hC6); push_done(4'd2);
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t2_hold_route", 16'(route), 16'h001B);
      check("t2_hold_pc",    16'(pc),    16'd0);
    end
    tick();
    op_ready = 1'b1;
    wait_idle("t2");

    // Sixteen words, none marked last.
    for (int i = 0; i < 16; i++) begin
      prog16[i] = {1'b0, 8'(i * 37 + 5)};
      write_word(4'(i), prog16[i]);
    end
    for (int i = 0; i < 16; i++) push_op(4'(i), prog16[i][7:0]);
    push_done(4'd15);
    pulse_start();
    tick(); tick();
    // Start and a program write while busy must both be dropped.
    start = 1'b1; prog_we = 1'b1; prog_addr = 4'd5; prog_data = 9'h1FF;
    tick();
    start = 1'b0; prog_we = 1'b0;
    wait_idle("t3");
    check("t3_pc_no_wrap", 16'(pc), 16'd15);

    // Abort at pc=2.
    push_op(4'd0, prog16[0][7:0]); push_op(4'd1, prog16[1][7:0]);
    pulse_start();
    for (int n = 0; n < 20 && pc != 4'd2; n++) tick();
    check("t5_reached_pc2", 16'(pc), 16'd2);
    op_ready = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
    check_quiet("t5_abort");
    tick(); tick();
    check("t5_no_done", 16'(done), 16'd0);

    // Reset at pc=5, then rerun the untouched program.
    op_ready = 1'b1;
    for (int i = 0; i < 5; i++) push_op(4'(i), prog16[i][7:0]);
    pulse_start();
    for (int n = 0; n < 20 && pc != 4'd5; n++) tick();
    check("t6_reached_pc5", 16'(pc), 16'd5);
    op_ready = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    check_quiet("t6_reset");
    op_ready = 1'b1;
    for (int i = 0; i < 16; i++) push_op(4'(i), prog16[i][7:0]);
    push_done(4'd15);
    pulse_start();
    wait_idle("t6");
    tick(); tick();

    check("leftover_expectations", 16'(exp_q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
